// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MIPS memory responder: FSM state encoding,
// the NOP instruction word and byte-address to word-index conversion.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    localparam logic [31:0] NOP_INST      = 32'h0000_0000;
    localparam int          CNT_W_DEFAULT = 16;

    // Full word index of a byte address; callers compare it against the depth
    // for range checks and slice the low bits to address the array.
    function automatic logic [29:0] word_idx(input logic [31:0] adr);
        return adr[31:2];
    endfunction

    // A byte address is usable as a word access only when its low bits are zero.
    function automatic logic is_aligned(input logic [31:0] adr);
        return (adr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/mips_mem_responder_mem_word_array.sv
// Word-wide storage array with one synchronous write port and one
// asynchronous read port. Contents are never cleared by reset.
module mem_word_array #(
    parameter int WORDS = 1024,
    localparam int AW   = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [WORDS];

    // Write on the rising edge; a read of the same word in that cycle sees the old value.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Zero-latency read path.
    always_comb begin
        rdata = mem_q[raddr];
    end

endmodule

// File: rtl/mips_mem_responder.sv
// Harvard instruction/data memory responder for the single-cycle MIPS core.
// A host fills both memories while the core is held in reset (LOAD), the core
// then runs against them (RUN), and any illegal access parks the block in a
// sticky FAULT state with the core held in reset until rst.
module mips_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int IMEM_WORDS = 1024,
    parameter int DMEM_WORDS = 1024,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst_adr,
    output logic [31:0]      inst,
    input  logic [31:0]      data_adr,
    input  logic [31:0]      data_out,
    output logic [31:0]      data_in,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic             ld_sel,
    input  logic [31:0]      ld_addr,
    input  logic [31:0]      ld_data,
    input  logic             ld_done,
    output logic             cpu_rst,
    output logic             fault,
    output logic [31:0]      fault_adr,
    output logic [CNT_W-1:0] wr_count
);

    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    state_e           state_q, state_d;
    logic             cpu_rst_q, cpu_rst_d;
    logic             ld_ready_q, ld_ready_d;
    logic             fault_q, fault_d;
    logic [31:0]      fault_adr_q, fault_adr_d;
    logic [CNT_W-1:0] wr_count_q, wr_count_d;

    logic [29:0]      inst_widx, data_widx, ld_widx;
    logic             inst_ok, data_ok, ld_imem_ok, ld_dmem_ok;
    logic             data_bad, inst_bad, fault_now;
    logic             ld_fire, store_ok;

    logic             imem_we, dmem_we;
    logic [IAW-1:0]   imem_waddr;
    logic [DAW-1:0]   dmem_waddr;
    logic [31:0]      dmem_wdata;
    logic [31:0]      imem_rdata, dmem_rdata;

    // Address decode and legality checks for the fetch, data and host-load ports.
    always_comb begin
        inst_widx  = word_idx(inst_adr);
        data_widx  = word_idx(data_adr);
        ld_widx    = word_idx(ld_addr);
        inst_ok    = is_aligned(inst_adr) && (inst_widx < 30'(IMEM_WORDS));
        data_ok    = is_aligned(data_adr) && (data_widx < 30'(DMEM_WORDS));
        ld_imem_ok = is_aligned(ld_addr)  && (ld_widx   < 30'(IMEM_WORDS));
        ld_dmem_ok = is_aligned(ld_addr)  && (ld_widx   < 30'(DMEM_WORDS));
    end

    // Fault detection and write qualification; rst suppresses every write in its cycle.
    always_comb begin
        data_bad  = ((mem_read || mem_write) && !data_ok) || (mem_read && mem_write);
        inst_bad  = !inst_ok;
        fault_now = (state_q == ST_RUN) && (data_bad || inst_bad);
        store_ok  = (state_q == ST_RUN) && mem_write && !fault_now && !rst;
        ld_fire   = (state_q == ST_LOAD) && ld_valid && ld_ready_q && !rst;
    end

    // Write-port muxing: host beats own both ports in LOAD, the core owns dmem in RUN.
    always_comb begin
        imem_we    = ld_fire && !ld_sel && ld_imem_ok;
        imem_waddr = ld_widx[IAW-1:0];
        if (state_q == ST_LOAD) begin
            dmem_we    = ld_fire && ld_sel && ld_dmem_ok;
            dmem_waddr = ld_widx[DAW-1:0];
            dmem_wdata = ld_data;
        end else begin
            dmem_we    = store_ok;
            dmem_waddr = data_widx[DAW-1:0];
            dmem_wdata = data_out;
        end
    end

    mem_word_array #(.WORDS(IMEM_WORDS)) u_imem (
        .clk   (clk),
        .we    (imem_we),
        .waddr (imem_waddr),
        .wdata (ld_data),
        .raddr (inst_widx[IAW-1:0]),
        .rdata (imem_rdata)
    );

    mem_word_array #(.WORDS(DMEM_WORDS)) u_dmem (
        .clk   (clk),
        .we    (dmem_we),
        .waddr (dmem_waddr),
        .wdata (dmem_wdata),
        .raddr (data_widx[DAW-1:0]),
        .rdata (dmem_rdata)
    );

    // Next-state logic: LOAD -> RUN on ld_done, RUN -> FAULT on any illegal access.
    always_comb begin
        state_d     = state_q;
        fault_d     = fault_q;
        fault_adr_d = fault_adr_q;
        wr_count_d  = wr_count_q;
        case (state_q)
            ST_LOAD: begin
                if (ld_done) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (fault_now) begin
                    state_d     = ST_FAULT;
                    fault_d     = 1'b1;
                    fault_adr_d = data_bad ? data_adr : inst_adr;
                end else if (store_ok && (wr_count_q != {CNT_W{1'b1}})) begin
                    wr_count_d = wr_count_q + CNT_W'(1);
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
        cpu_rst_d  = (state_d != ST_RUN);
        ld_ready_d = (state_d == ST_LOAD);
    end

    // FSM state and registered control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            cpu_rst_q   <= 1'b1;
            ld_ready_q  <= 1'b1;
            fault_q     <= 1'b0;
            fault_adr_q <= 32'h0;
            wr_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            cpu_rst_q   <= cpu_rst_d;
            ld_ready_q  <= ld_ready_d;
            fault_q     <= fault_d;
            fault_adr_q <= fault_adr_d;
            wr_count_q  <= wr_count_d;
        end
    end

    // Read data to the core: only live in RUN, NOP/zero everywhere else.
    always_comb begin
        inst    = NOP_INST;
        data_in = 32'h0;
        if (state_q == ST_RUN) begin
            if (inst_ok) begin
                inst = imem_rdata;
            end
            if (mem_read) begin
                data_in = dmem_rdata;
            end
        end
    end

    assign cpu_rst   = cpu_rst_q;
    assign ld_ready  = ld_ready_q;
    assign fault     = fault_q;
    assign fault_adr = fault_adr_q;
    assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench for mips_mem_responder: load, run, store/load, faults,
// reset recovery with memory retention and store-counter saturation.
module tb_mips_mem_responder;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      inst_adr, inst;
    logic [31:0]      data_adr, data_out, data_in;
    logic             mem_read, mem_write;
    logic             ld_valid, ld_ready, ld_sel, ld_done;
    logic [31:0]      ld_addr, ld_data;
    logic             cpu_rst, fault;
    logic [31:0]      fault_adr;
    logic [CNT_W-1:0] wr_count;

    int n_checks = 0;
    int n_errors = 0;

    mips_mem_responder #(
        .IMEM_WORDS (1024),
        .DMEM_WORDS (1024),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .inst_adr  (inst_adr),
        .inst      (inst),
        .data_adr  (data_adr),
        .data_out  (data_out),
        .data_in   (data_in),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_sel    (ld_sel),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_done   (ld_done),
        .cpu_rst   (cpu_rst),
        .fault     (fault),
        .fault_adr (fault_adr),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then driven and settle mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic reset_then_run();
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        ld_done = 1'b1;
        tick();
        ld_done = 1'b0;
    endtask

    initial begin
        rst = 1'b1; inst_adr = 32'h0; data_adr = 32'h0; data_out = 32'h0;
        mem_read = 1'b0; mem_write = 1'b0; ld_valid = 1'b0; ld_sel = 1'b0;
        ld_addr = 32'h0; ld_data = 32'h0; ld_done = 1'b0;

        // Reset held for two cycles
        tick();
        tick();
        settle();
        chk("rst_cpu_rst",  32'(cpu_rst),  32'h1);
        chk("rst_ld_ready", 32'(ld_ready), 32'h1);
        chk("rst_fault",    32'(fault),    32'h0);
        chk("rst_fault_adr", fault_adr,    32'h0);
        chk("rst_wr_count", 32'(wr_count), 32'h0);
        chk("rst_inst",     inst,          32'h0);

        // Host load: imem[0], dmem[4], then a misaligned imem beat that must be dropped
        rst = 1'b0;
        ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 32'h0;  ld_data = 32'h2008_0005;
        tick();
        ld_sel = 1'b1;   ld_addr = 32'h10; ld_data = 32'h1111_1111;
        tick();
        ld_sel = 1'b0;   ld_addr = 32'h2;  ld_data = 32'hFFFF_FFFF;
        tick();
        ld_valid = 1'b0;
        settle();
        chk("load_inst_nop", inst,          32'h0);
        chk("load_ld_ready", 32'(ld_ready), 32'h1);
        chk("load_cpu_rst",  32'(cpu_rst),  32'h1);
        ld_done = 1'b1;
        tick();
        ld_done = 1'b0;
        settle();
        chk("run_cpu_rst",  32'(cpu_rst),  32'h0);
        chk("run_ld_ready", 32'(ld_ready), 32'h0);
        chk("run_inst0",    inst,          32'h2008_0005);

        // Store then load at 0x10
        mem_write = 1'b1; data_adr = 32'h10; data_out = 32'hDEAD_BEEF;
        tick();
        mem_write = 1'b0; mem_read = 1'b1;
        settle();
        chk("load_after_store", data_in,       32'hDEAD_BEEF);
        chk("wr_count_one",     32'(wr_count), 32'h1);
        tick();

        // Misaligned store faults, is suppressed and does not count
        mem_read = 1'b0; mem_write = 1'b1; data_adr = 32'h13; data_out = 32'hCAFE_F00D;
        tick();
        mem_write = 1'b0;
        settle();
        chk("mis_fault",     32'(fault),    32'h1);
        chk("mis_fault_adr", fault_adr,     32'h13);
        chk("mis_cpu_rst",   32'(cpu_rst),  32'h1);
        chk("mis_wr_count",  32'(wr_count), 32'h1);
        chk("fault_inst",    inst,          32'h0);
        tick();
        chk("fault_sticky",  32'(fault),    32'h1);

        // Reset clears fault and counter, memories retained
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk("rst2_fault",    32'(fault),    32'h0);
        chk("rst2_wr_count", 32'(wr_count), 32'h0);
        chk("rst2_ld_ready", 32'(ld_ready), 32'h1);
        ld_done = 1'b1;
        tick();
        ld_done = 1'b0;
        mem_read = 1'b1; data_adr = 32'h10;
        settle();
        chk("dmem4_intact", data_in, 32'hDEAD_BEEF);
        chk("imem0_intact", inst,    32'h2008_0005);

        // Read and write together: old word seen this cycle, then fault, store dropped
        mem_write = 1'b1; data_out = 32'h1234_5678;
        settle();
        chk("same_cycle_old", data_in, 32'hDEAD_BEEF);
        tick();
        mem_read = 1'b0; mem_write = 1'b0;
        settle();
        chk("rw_fault",     32'(fault), 32'h1);
        chk("rw_fault_adr", fault_adr,  32'h10);

        // Out-of-range fetch
        reset_then_run();
        inst_adr = 32'h1000;
        settle();
        chk("oor_inst_nop", inst, 32'h0);
        tick();
        inst_adr = 32'h0;
        settle();
        chk("oor_fault",     32'(fault),   32'h1);
        chk("oor_fault_adr", fault_adr,    32'h1000);
        chk("oor_cpu_rst",   32'(cpu_rst), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk("oor_rst_fault",    32'(fault),    32'h0);
        chk("oor_rst_ld_ready", 32'(ld_ready), 32'h1);

        // ld_done with a beat in the same cycle: beat written and RUN entered
        ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 32'h4; ld_data = 32'hABCD_0001; ld_done = 1'b1;
        tick();
        ld_valid = 1'b0; ld_done = 1'b0; inst_adr = 32'h4;
        mem_read = 1'b1; data_adr = 32'h10;
        settle();
        chk("done_beat_cpu_rst", 32'(cpu_rst), 32'h0);
        chk("done_beat_inst",    inst,         32'hABCD_0001);
        chk("dmem_after_rw",     data_in,      32'hDEAD_BEEF);
        tick();

        // 20 stores saturate a 4-bit counter at 15
        mem_read = 1'b0;
        for (int i = 0; i < 20; i++) begin
            mem_write = 1'b1; data_adr = 32'h20 + 32'(4 * i); data_out = 32'(i);
            tick();
        end
        mem_write = 1'b0;
        settle();
        chk("sat_wr_count", 32'(wr_count), 32'hF);
        chk("sat_fault",    32'(fault),    32'h0);
        mem_read = 1'b1; data_adr = 32'h20 + 32'(4 * 19);
        settle();
        chk("sat_last_word", data_in, 32'd19);
        data_adr = 32'h20;
        settle();
        chk("sat_first_word", data_in, 32'd0);

        // Data fault takes priority over a simultaneous fetch fault
        inst_adr = 32'h2; data_adr = 32'h1000;
        tick();
        mem_read = 1'b0; inst_adr = 32'h0;
        settle();
        chk("prio_fault",     32'(fault),    32'h1);
        chk("prio_fault_adr", fault_adr,     32'h1000);
        chk("prio_wr_count",  32'(wr_count), 32'hF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
